// File: rtl/lcd_cmd_sequencer.sv
// Command feeder for the 8x8 LCD image controller: buffers host commands in a FIFO
// and issues them one at a time over the controller's busy/cmd/cmd_valid handshake.
// States: IDLE wait for head/busy=0 | ISSUE strobe out | WAIT busy rise or timeout | HALT after 4'hF
module lcd_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_push,
  input  logic [3:0]                 host_cmd,
  output logic                       host_full,
  output logic [$clog2(DEPTH):0]     host_count,
  input  logic                       busy,
  input  logic                       done,
  output logic [3:0]                 cmd,
  output logic                       cmd_valid,
  output logic [7:0]                 issued_cnt,
  output logic                       overflow,
  output logic                       timeout_err,
  output logic                       finished
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [3:0] CMD_NOP  = 4'hE;
  localparam logic [3:0] CMD_TERM = 4'hF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer, timer_nxt;
  logic [3:0]      head, cmd_nxt;
  logic            push_ok, pop, empty;
  logic            valid_nxt, cnt_inc, to_set, fin_set;

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign host_full  = (count == CW'(DEPTH));
  assign host_count = count;
  assign push_ok    = host_push && !host_full;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= host_cmd;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (host_push && host_full) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    cmd_nxt   = CMD_NOP;
    valid_nxt = 1'b0;
    cnt_inc   = 1'b0;
    timer_nxt = timer;
    to_set    = 1'b0;
    fin_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && head == CMD_NOP) begin
          pop = 1'b1;
        end else if (!empty && !busy) begin
          pop       = 1'b1;
          cmd_nxt   = head;
          valid_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_inc   = 1'b1;
        timer_nxt = '0;
        state_nxt = (cmd == CMD_TERM) ? HALT : WAIT;
      end
      WAIT: begin
        if (busy) begin
          state_nxt = IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          to_set    = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      HALT: begin
        if (done) fin_set = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= CMD_NOP;
      cmd_valid   <= 1'b0;
      issued_cnt  <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      finished    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      cmd_valid <= valid_nxt;
      timer     <= timer_nxt;
      if (cnt_inc) issued_cnt  <= issued_cnt + 8'd1;
      if (to_set)  timeout_err <= 1'b1;
      if (fin_set) finished    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: expected commands are queued at push time
// and matched against strobes captured by a negedge monitor.
module tb_lcd_cmd_sequencer;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst, host_push, busy, done;
  logic [3:0] host_cmd;
  logic       host_full;
  logic [3:0] host_count;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] issued_cnt;
  logic       overflow, timeout_err, finished;

  logic       busy_hold, auto_busy, busy_pulse;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  int         pulse_cnt;
  logic       prev_valid;
  bit         b2b_seen, idle_cmd_bad;
  int         n_pass = 0;
  int         n_total = 0;

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .host_push(host_push), .host_cmd(host_cmd),
    .host_full(host_full), .host_count(host_count), .busy(busy), .done(done),
    .cmd(cmd), .cmd_valid(cmd_valid), .issued_cnt(issued_cnt), .overflow(overflow),
    .timeout_err(timeout_err), .finished(finished)
  );

  always #5 clk = ~clk;

  // Controller model: busy rises for one cycle right after each sampled strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_pulse <= 1'b0;
    else     busy_pulse <= cmd_valid;
  end
  assign busy = busy_hold | (auto_busy & busy_pulse);

  always @(negedge clk) begin
    if (rst) begin
      obs_q.delete();
      pulse_cnt    = 0;
      prev_valid   = 1'b0;
      b2b_seen     = 1'b0;
      idle_cmd_bad = 1'b0;
    end else begin
      if (cmd_valid) begin
        obs_q.push_back(cmd);
        pulse_cnt++;
        if (prev_valid) b2b_seen = 1'b1;
      end else if (cmd !== 4'hE) begin
        idle_cmd_bad = 1'b1;
      end
      prev_valid = cmd_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] v);
    host_push = 1'b1;
    host_cmd  = v;
    tick(1);
    host_push = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    host_push = 1'b0;
    host_cmd  = 4'h0;
    done      = 1'b0;
    busy_hold = 1'b0;
    auto_busy = 1'b0;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while (pulse_cnt < n && k < budget) begin
      tick(1);
      k++;
    end
    if (pulse_cnt < n) begin
      n_total++;
      $display("FAIL wait_pulses got %0d want %0d within %0d cycles", pulse_cnt, n, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (cmd !== 4'hE)        $display("FAIL reset_cmd got %h want e", cmd); else n_pass++;
    n_total++; if (cmd_valid !== 1'b0)  $display("FAIL reset_valid got %b want 0", cmd_valid); else n_pass++;
    n_total++; if (issued_cnt !== 8'd0) $display("FAIL reset_issued got %0d want 0", issued_cnt); else n_pass++;
    n_total++; if (overflow !== 1'b0)   $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout_err); else n_pass++;
    n_total++; if (finished !== 1'b0)   $display("FAIL reset_finished got %b want 0", finished); else n_pass++;
    n_total++; if (host_count !== 4'd0) $display("FAIL reset_count got %0d want 0", host_count); else n_pass++;
    n_total++; if (host_full !== 1'b0)  $display("FAIL reset_full got %b want 0", host_full); else n_pass++;
  endtask

  task automatic test_sequence();
    logic [3:0] e, o;
    do_reset();
    auto_busy = 1'b1;
    push(4'd2);  exp_q.push_back(4'd2);
    push(4'd5);  exp_q.push_back(4'd5);
    push(4'd15); exp_q.push_back(4'd15);
    wait_pulses(3, 60);
    tick(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL seq_cmd got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL seq_cmd got %h want %h", o, e); else n_pass++;
      end
    end
    n_total++; if (pulse_cnt !== 3)     $display("FAIL seq_pulses got %0d want 3", pulse_cnt); else n_pass++;
    n_total++; if (issued_cnt !== 8'd3) $display("FAIL seq_issued got %0d want 3", issued_cnt); else n_pass++;
    n_total++; if (b2b_seen !== 1'b0)   $display("FAIL seq_back_to_back got %b want 0", b2b_seen); else n_pass++;
    n_total++; if (idle_cmd_bad !== 1'b0) $display("FAIL seq_idle_cmd got %b want 0", idle_cmd_bad); else n_pass++;
    n_total++; if (finished !== 1'b0)   $display("FAIL seq_finished_early got %b want 0", finished); else n_pass++;
    done = 1'b1;
    tick(1);
    n_total++; if (finished !== 1'b1)   $display("FAIL seq_finished got %b want 1", finished); else n_pass++;
    done = 1'b0;
  endtask

  task automatic test_overflow();
    logic [3:0] e, o;
    do_reset();
    busy_hold = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      push(4'(i));
      if (i <= DEPTH) exp_q.push_back(4'(i));
      if (i == 7) begin
        n_total++; if (host_full !== 1'b0) $display("FAIL ovf_full7 got %b want 0", host_full); else n_pass++;
      end
      if (i == 8) begin
        n_total++; if (host_full !== 1'b1)  $display("FAIL ovf_full8 got %b want 1", host_full); else n_pass++;
        n_total++; if (host_count !== 4'd8) $display("FAIL ovf_count8 got %0d want 8", host_count); else n_pass++;
        n_total++; if (overflow !== 1'b0)   $display("FAIL ovf_flag8 got %b want 0", overflow); else n_pass++;
      end
    end
    n_total++; if (overflow !== 1'b1)   $display("FAIL ovf_flag9 got %b want 1", overflow); else n_pass++;
    n_total++; if (host_count !== 4'd8) $display("FAIL ovf_count9 got %0d want 8", host_count); else n_pass++;
    n_total++; if (pulse_cnt !== 0)     $display("FAIL ovf_pulses got %0d want 0", pulse_cnt); else n_pass++;
    busy_hold = 1'b0;
    auto_busy = 1'b1;
    wait_pulses(8, 120);
    tick(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL ovf_order got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL ovf_order got %h want %h", o, e); else n_pass++;
      end
    end
    n_total++; if (obs_q.size() != 0)   $display("FAIL ovf_extra got %0d want 0", obs_q.size()); else n_pass++;
    n_total++; if (issued_cnt !== 8'd8) $display("FAIL ovf_issued got %0d want 8", issued_cnt); else n_pass++;
    n_total++; if (host_count !== 4'd0) $display("FAIL ovf_drained got %0d want 0", host_count); else n_pass++;
  endtask

  task automatic test_noop();
    do_reset();
    push(4'hE);
    push(4'hE);
    push(4'd7);
    n_total++; if (host_count !== 4'd1) $display("FAIL nop_count got %0d want 1", host_count); else n_pass++;
    n_total++; if (cmd_valid !== 1'b0)  $display("FAIL nop_valid_early got %b want 0", cmd_valid); else n_pass++;
    tick(1);
    n_total++; if (cmd_valid !== 1'b1)  $display("FAIL nop_valid got %b want 1", cmd_valid); else n_pass++;
    n_total++; if (cmd !== 4'd7)        $display("FAIL nop_cmd got %h want 7", cmd); else n_pass++;
    tick(2);
    n_total++; if (issued_cnt !== 8'd1) $display("FAIL nop_issued got %0d want 1", issued_cnt); else n_pass++;
    n_total++; if (pulse_cnt !== 1)     $display("FAIL nop_pulses got %0d want 1", pulse_cnt); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [3:0] e, o;
    int k;
    do_reset();
    push(4'd0); exp_q.push_back(4'd0);
    k = 0;
    while (cmd_valid !== 1'b1 && k < 10) begin
      tick(1);
      k++;
    end
    n_total++; if (cmd_valid !== 1'b1) $display("FAIL to_issue got %b want 1", cmd_valid); else n_pass++;
    tick(TIMEOUT);
    n_total++; if (timeout_err !== 1'b0) $display("FAIL to_early got %b want 0", timeout_err); else n_pass++;
    tick(1);
    n_total++; if (timeout_err !== 1'b1) $display("FAIL to_flag got %b want 1", timeout_err); else n_pass++;
    push(4'd6); exp_q.push_back(4'd6);
    wait_pulses(2, 10);
    tick(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL to_cmd got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL to_cmd got %h want %h", o, e); else n_pass++;
      end
    end
    n_total++; if (issued_cnt !== 8'd2) $display("FAIL to_issued got %0d want 2", issued_cnt); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    auto_busy = 1'b1;
    push(4'hF);
    wait_pulses(1, 20);
    tick(2);
    push(4'd3);
    tick(10);
    n_total++; if (host_count !== 4'd1) $display("FAIL halt_count got %0d want 1", host_count); else n_pass++;
    n_total++; if (cmd !== 4'hE)        $display("FAIL halt_cmd got %h want e", cmd); else n_pass++;
    n_total++; if (pulse_cnt !== 1)     $display("FAIL halt_pulses got %0d want 1", pulse_cnt); else n_pass++;
    n_total++; if (issued_cnt !== 8'd1) $display("FAIL halt_issued got %0d want 1", issued_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    push(4'd4);
    push(4'd1);
    push(4'd2);
    push(4'd3);
    n_total++; if (host_count !== 4'd3) $display("FAIL rmw_count_pre got %0d want 3", host_count); else n_pass++;
    n_total++; if (issued_cnt !== 8'd1) $display("FAIL rmw_issued_pre got %0d want 1", issued_cnt); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (host_count !== 4'd0) $display("FAIL rmw_count got %0d want 0", host_count); else n_pass++;
    n_total++; if (issued_cnt !== 8'd0) $display("FAIL rmw_issued got %0d want 0", issued_cnt); else n_pass++;
    n_total++; if (cmd !== 4'hE || cmd_valid !== 1'b0)
      $display("FAIL rmw_cmd got %h/%b want e/0", cmd, cmd_valid); else n_pass++;
    n_total++; if (timeout_err !== 1'b0 || overflow !== 1'b0 || finished !== 1'b0)
      $display("FAIL rmw_flags got %b%b%b want 000", timeout_err, overflow, finished); else n_pass++;
    tick(1);
    rst = 1'b0;
    tick(10);
    n_total++; if (pulse_cnt !== 0)     $display("FAIL rmw_pulses got %0d want 0", pulse_cnt); else n_pass++;
    n_total++; if (host_count !== 4'd0) $display("FAIL rmw_count_post got %0d want 0", host_count); else n_pass++;
    push(4'd5);
    wait_pulses(1, 10);
    tick(1);
    n_total++;
    if (obs_q.size() == 0) $display("FAIL rmw_new got none want 5");
    else if (obs_q[0] !== 4'd5) $display("FAIL rmw_new got %h want 5", obs_q[0]);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    host_push  = 1'b0;
    host_cmd   = 4'h0;
    done       = 1'b0;
    busy_hold  = 1'b0;
    auto_busy  = 1'b0;
    test_reset();
    test_sequence();
    test_overflow();
    test_noop();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Upstream command feeder for the 8x8 LCD image controller.
- Buffers 4-bit commands pushed by the host or testbench in a small FIFO.
- Issues them to the controller one at a time using the controller's busy/cmd/cmd_valid handshake.
- Halts after issuing the terminate command (4'hF) and reports completion once the controller raises done.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT, 16, cycles allowed for busy to rise after an issue before timeout_err is flagged.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- host_push  in  1  write host_cmd into the FIFO this cycle.
- host_cmd  in  4  command code: 0 write, 1-4 move, 5-13 ops, 14 no-op, 15 done.
- host_full  out  1  FIFO full; a push this cycle is rejected.
- host_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  in  1  controller busy; 0 means the controller is sampling cmd.
- done  in  1  controller finished.
- cmd  out  4  command to the controller; 4'hE when no command is being issued.
- cmd_valid  out  1  one-cycle issue strobe.
- issued_cnt  out  8  number of commands issued; wraps 255->0.
- overflow  out  1  sticky; set when a push is attempted while full.
- timeout_err  out  1  sticky; set when busy fails to rise within TIMEOUT cycles.
- finished  out  1  set once done is seen while in HALT.

Behaviour:
- Reset values: cmd=4'hE, cmd_valid=0, issued_cnt=0, overflow=0, timeout_err=0, finished=0, FIFO empty, host_count=0, host_full=0, state IDLE. Reset mid-operation discards all FIFO contents and abandons any in-flight issue.
- All outputs are registered except host_full and host_count, which are decoded combinationally from the occupancy counter.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - host_full = (count == DEPTH).
  - A push while full is dropped, sets overflow, and leaves count unchanged. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted push and pop leaves count unchanged.
  - FIFO order is strictly preserved.
- IDLE:
  - If FIFO non-empty and head == 4'hE: pop and discard. No issue, no busy dependence, one cycle per no-op.
  - Else if FIFO non-empty and busy == 0: pop the head, register cmd=head and cmd_valid=1, go to ISSUE.
  - Else stay in IDLE.
- ISSUE (one cycle):
  - The controller samples cmd on this cycle's closing edge.
  - On exit: cmd_valid=0, cmd=4'hE, issued_cnt+1, timer cleared.
  - Next state is HALT if the issued command was 4'hF, else WAIT.
- WAIT:
  - If busy == 1 go to IDLE; the next issue needs busy to return to 0.
  - Else increment the timer. When timer reaches TIMEOUT-1, set timeout_err and go to IDLE anyway.
  - The FIFO still accepts pushes during WAIT.
- HALT:
  - Terminal; no further pops or issues. Pushes are still accepted until full.
  - finished is set the cycle after done is sampled high and stays set until rst.
- No back-to-back strobes: at least ISSUE plus one WAIT cycle separates consecutive cmd_valid pulses.
- cmd is driven to 4'hE whenever cmd_valid=0, so an idle controller stays in its command-read state.
- issued_cnt counts every issued command including 4'hF. Discarded no-ops are not counted.

Test Plan:
- Reset, then push 2,5,15 with busy pulsing high for one cycle after each sample:
  - cmd_valid pulses exactly 3 times, with cmd=2, 5, 15 in order.
  - issued_cnt=3.
  - Raising done gives finished=1 one cycle later.
- Push 9 pushes with DEPTH=8 and busy held 1:
  - host_full=1 after the 8th push; the 9th sets overflow=1.
  - host_count stays 8; no cmd_valid pulses.
- Push 14,14,7 with busy=0:
  - Two no-ops are discarded in 2 cycles; only cmd=7 is issued.
  - issued_cnt=1.
- Issue cmd 0 with busy kept 0 for 20 cycles:
  - timeout_err=1 exactly TIMEOUT cycles after the ISSUE cycle.
  - The sequencer returns to IDLE.
- After 4'hF issues, push 3:
  - Accepted into the FIFO (host_count=1) but never issued; cmd stays 4'hE.
- Assert rst while in WAIT with 3 entries queued:
  - All outputs return to reset values and host_count=0.
  - After rst release, nothing issues until new pushes arrive.
